hzu_sb: RTL and testbench
=========================

Name: hzu_sb

Overview:
- Parametrised successor to the combinational hazard/forwarding unit.
- Adds a register scoreboard that tracks outstanding long-latency writes, e.g. a multi-cycle mul/div issued from EX that completes out of band through a completion port.
- Retains EX/MEM/WB forwarding selection, load-use and store-data stalls, and branch flush generation.
- Store-data WB stall is selectable by parameter; adds a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural registers; must equal 2**REG_AW.
- MAX_PEND, 4, max outstanding long-latency writes.
- CNT_W, $clog2(MAX_PEND+1), pending-counter width.
- STORE_WB_FWD, 1, 1: store-in-ID with WB producer does not stall (register file is write-through); 0: conservative stall.
- STALL_CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs1_addr_id, rs2_addr_id  in  REG_AW  ID source regs
- rs1_used_id, rs2_used_id  in  1  ID instruction reads rs1/rs2
- rd_addr_id  in  REG_AW  ID destination
- rd_we_id  in  1  ID instruction writes rd
- is_store_id  in  1  ID is store
- is_long_id  in  1  ID is long-latency op
- issue_valid_ex  in  1  EX holds a valid instruction
- rd_addr_ex  in  REG_AW  EX destination
- rd_we_ex  in  1  EX writes rd
- is_load_ex  in  1  EX is load
- is_long_ex  in  1  EX is long-latency op
- rs1_addr_ex, rs2_addr_ex  in  REG_AW  EX sources
- tk_brnch_ex  in  1  taken branch in EX
- rd_addr_mem  in  REG_AW  MEM destination
- rd_we_mem  in  1  MEM writes rd
- is_load_mem  in  1  MEM is load
- is_store_mem  in  1  MEM is store
- rs2_addr_mem  in  REG_AW  MEM store-data reg
- rd_addr_wb  in  REG_AW  WB destination
- rd_we_wb  in  1  WB writes rd
- lr_done  in  1  long-latency result written this cycle
- lr_rd_addr  in  REG_AW  destination of completing result
- forward_a_sel, forward_b_sel  out  2  00 regfile, 01 MEM, 10 WB
- forward_store_sel  out  1  1 = WB data to MEM store
- stall  out  1  hold PC and IF/ID
- flush_if_id, flush_id_ex  out  1  pipeline flushes
- sb_busy  out  NUM_REGS  scoreboard busy bits
- pend_cnt  out  CNT_W  outstanding long writes
- sb_full  out  1  pend_cnt == MAX_PEND
- err_spurious  out  1  sticky: completion for non-busy register
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): sb_busy=0, pend_cnt=0, sb_full=0, err_spurious=0, stall_cnt=0. Combinational outputs follow their inputs with zeroed state. Reset mid-operation discards all pending entries.
- Dependency: match requires equal addresses, producer we=1 and rd!=0.
- Forwarding (EX consumer): MEM non-load match -> 01; else WB match -> 10; else 00. Store: rs2_addr_mem matches WB and is_store_mem -> 1.
- set_ev = issue_valid_ex & is_long_ex & rd_we_ex & rd_addr_ex!=0.
- clr_ev = lr_done & lr_rd_addr!=0 & sb_busy[lr_rd_addr].
- busy_eff = sb_busy | onehot(rd_addr_ex) when set_ev. Clears take effect the cycle after lr_done: no completion bypass, 1-cycle conservative stall.
- Stall sources, any asserted:
  - Load-use on rs1, or on rs2 if not a store.
  - Store-data from a load in EX or MEM.
  - Store-data from WB, only when STORE_WB_FWD=0.
  - rs1_used_id & busy_eff[rs1]; rs2_used_id & busy_eff[rs2].
  - WAW: rd_we_id & busy_eff[rd_addr_id].
  - is_long_id & (pend_cnt + set_ev) == MAX_PEND.
- flush_if_id = tk_brnch_ex; flush_id_ex = tk_brnch_ex | stall. Branch flush never clears the scoreboard, since issued long ops are older than the branch.
- Sequential update on clk rising edge:
  - set_ev sets the bit and increments pend_cnt.
  - clr_ev clears the bit and decrements pend_cnt.
  - Both on different regs: pend_cnt unchanged.
  - Both on the same reg: set wins, pend_cnt unchanged.
- lr_done with rd=0 or a non-busy reg: ignored, err_spurious set until reset.
- set_ev while pend_cnt==MAX_PEND must not occur (guarded by the ID stall). The counter must not wrap; if it occurs, assertion fails.
- stall_cnt increments each cycle stall=1 and saturates at all-ones.

Test Plan:
- Long op rd=x5 in EX, next ID reads x5 -> stall that cycle via busy_eff; sb_busy[5]=1, pend_cnt=1. lr_done x5 at cycle N -> stall at N, released at N+1, pend_cnt=0.
- Four long ops x1..x4, fifth long op in ID -> sb_full=1, stall=1 until any lr_done. Concurrent set and clear on different regs -> pend_cnt stays 4.
- Load x7 in EX, ID add uses x7 -> stall one cycle; then forward_a_sel=10. ALU x7 in MEM -> forward_a_sel=01 over WB x7.
- Store in ID, rs2=x9 produced in WB -> STORE_WB_FWD=1: no stall; =0: stall=1. Store in MEM with WB x9 -> forward_store_sel=1.
- lr_done for non-busy x3 -> err_spurious=1 sticky, state unchanged. Assert rst_n=0 mid-operation with pend_cnt=2 -> all state 0 immediately.
- Hold stall 70000 cycles with STALL_CNT_W=16 -> stall_cnt saturates at 65535. tk_brnch_ex=1 -> flush_if_id=flush_id_ex=1, sb_busy unchanged.

Source files
------------

// File: rtl/hzu_sb_if.sv
// hzu_sb_if: pipeline-side signal bundle for the hazard/scoreboard unit.
// master = pipeline control driving stage info; slave = hzu_sb.
`timescale 1ns/1ps
interface hzu_sb_if #(
  parameter int REG_AW      = 5,
  parameter int NUM_REGS    = 32,
  parameter int MAX_PEND    = 4,
  parameter int CNT_W       = $clog2(MAX_PEND + 1),
  parameter int STALL_CNT_W = 16
);
  logic [REG_AW-1:0]      rs1_addr_id, rs2_addr_id, rd_addr_id;
  logic                   rs1_used_id, rs2_used_id, rd_we_id, is_store_id, is_long_id;
  logic                   issue_valid_ex, rd_we_ex, is_load_ex, is_long_ex, tk_brnch_ex;
  logic [REG_AW-1:0]      rd_addr_ex, rs1_addr_ex, rs2_addr_ex;
  logic [REG_AW-1:0]      rd_addr_mem, rs2_addr_mem;
  logic                   rd_we_mem, is_load_mem, is_store_mem;
  logic [REG_AW-1:0]      rd_addr_wb;
  logic                   rd_we_wb;
  logic                   lr_done;
  logic [REG_AW-1:0]      lr_rd_addr;
  logic [1:0]             forward_a_sel, forward_b_sel;
  logic                   forward_store_sel, stall, flush_if_id, flush_id_ex;
  logic [NUM_REGS-1:0]    sb_busy;
  logic [CNT_W-1:0]       pend_cnt;
  logic                   sb_full, err_spurious;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, rd_addr_id, rd_we_id,
           is_store_id, is_long_id, issue_valid_ex, rd_addr_ex, rd_we_ex, is_load_ex,
           is_long_ex, rs1_addr_ex, rs2_addr_ex, tk_brnch_ex, rd_addr_mem, rd_we_mem,
           is_load_mem, is_store_mem, rs2_addr_mem, rd_addr_wb, rd_we_wb, lr_done, lr_rd_addr,
    input  forward_a_sel, forward_b_sel, forward_store_sel, stall, flush_if_id, flush_id_ex,
           sb_busy, pend_cnt, sb_full, err_spurious, stall_cnt
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, rd_addr_id, rd_we_id,
           is_store_id, is_long_id, issue_valid_ex, rd_addr_ex, rd_we_ex, is_load_ex,
           is_long_ex, rs1_addr_ex, rs2_addr_ex, tk_brnch_ex, rd_addr_mem, rd_we_mem,
           is_load_mem, is_store_mem, rs2_addr_mem, rd_addr_wb, rd_we_wb, lr_done, lr_rd_addr,
    output forward_a_sel, forward_b_sel, forward_store_sel, stall, flush_if_id, flush_id_ex,
           sb_busy, pend_cnt, sb_full, err_spurious, stall_cnt
  );
endinterface

// File: rtl/hzu_sb.sv
// hzu_sb: hazard/forwarding unit with a scoreboard for out-of-band
// long-latency writebacks, plus a saturating stall-cycle counter.
`timescale 1ns/1ps
module hzu_sb #(
  parameter int REG_AW       = 5,
  parameter int NUM_REGS     = 32,
  parameter int MAX_PEND     = 4,
  parameter int CNT_W        = $clog2(MAX_PEND + 1),
  parameter bit STORE_WB_FWD = 1'b1,
  parameter int STALL_CNT_W  = 16
) (
  input logic   clk,
  input logic   rst_n,
  hzu_sb_if.slave hz
);

  logic [NUM_REGS-1:0]    sb_busy_q, busy_eff, busy_nx, set_mask, clr_mask;
  logic [CNT_W-1:0]       pend_q;
  logic [CNT_W:0]         pend_plus;
  logic                   err_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   set_ev, clr_ev, full_w, stall_w;
  logic                   st_lu, st_store, st_sb;

  // Producer/consumer match; x0 is never a real dependency.
  function automatic logic dep(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst,
                               input logic we);
    return we && (src == dst) && (dst != '0);
  endfunction

  // Scoreboard events and effective busy view (issuing op counts as busy, completions do not bypass).
  always_comb begin
    set_ev   = hz.issue_valid_ex & hz.is_long_ex & hz.rd_we_ex & (hz.rd_addr_ex != '0);
    clr_ev   = hz.lr_done & (hz.lr_rd_addr != '0) & sb_busy_q[hz.lr_rd_addr];
    set_mask = '0;
    clr_mask = '0;
    if (set_ev) set_mask[hz.rd_addr_ex] = 1'b1;
    if (clr_ev) clr_mask[hz.lr_rd_addr] = 1'b1;
    busy_eff  = sb_busy_q | set_mask;
    busy_nx   = (sb_busy_q & ~clr_mask) | set_mask;
    pend_plus = {1'b0, pend_q} + {{CNT_W{1'b0}}, set_ev};
    full_w    = (pend_q == CNT_W'(MAX_PEND));
  end

  // Forwarding selection and stall/flush generation.
  always_comb begin
    hz.forward_a_sel = 2'b00;
    hz.forward_b_sel = 2'b00;
    if (dep(hz.rs1_addr_ex, hz.rd_addr_mem, hz.rd_we_mem & ~hz.is_load_mem))
      hz.forward_a_sel = 2'b01;
    else if (dep(hz.rs1_addr_ex, hz.rd_addr_wb, hz.rd_we_wb))
      hz.forward_a_sel = 2'b10;
    if (dep(hz.rs2_addr_ex, hz.rd_addr_mem, hz.rd_we_mem & ~hz.is_load_mem))
      hz.forward_b_sel = 2'b01;
    else if (dep(hz.rs2_addr_ex, hz.rd_addr_wb, hz.rd_we_wb))
      hz.forward_b_sel = 2'b10;
    hz.forward_store_sel = hz.is_store_mem & dep(hz.rs2_addr_mem, hz.rd_addr_wb, hz.rd_we_wb);

    st_lu = hz.is_load_ex &
            ((hz.rs1_used_id & dep(hz.rs1_addr_id, hz.rd_addr_ex, hz.rd_we_ex)) |
             (hz.rs2_used_id & ~hz.is_store_id & dep(hz.rs2_addr_id, hz.rd_addr_ex, hz.rd_we_ex)));
    st_store = hz.is_store_id &
               ((hz.is_load_ex  & dep(hz.rs2_addr_id, hz.rd_addr_ex,  hz.rd_we_ex)) |
                (hz.is_load_mem & dep(hz.rs2_addr_id, hz.rd_addr_mem, hz.rd_we_mem)) |
                (!STORE_WB_FWD  & dep(hz.rs2_addr_id, hz.rd_addr_wb,  hz.rd_we_wb)));
    st_sb = (hz.rs1_used_id & busy_eff[hz.rs1_addr_id]) |
            (hz.rs2_used_id & busy_eff[hz.rs2_addr_id]) |
            (hz.rd_we_id    & busy_eff[hz.rd_addr_id]) |
            (hz.is_long_id  & (pend_plus == (CNT_W + 1)'(MAX_PEND)));
    stall_w = st_lu | st_store | st_sb;

    hz.stall       = stall_w;
    hz.flush_if_id = hz.tk_brnch_ex;
    hz.flush_id_ex = hz.tk_brnch_ex | stall_w;
  end

  // Scoreboard, pending count, sticky error and stall counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy_q   <= '0;
      pend_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_busy_q <= busy_nx;
      // Set+clear on the same cycle leaves the count unchanged whether or not the regs differ.
      unique case ({set_ev, clr_ev})
        2'b10:   if (!full_w) pend_q <= pend_q + CNT_W'(1);
        2'b01:   pend_q <= pend_q - CNT_W'(1);
        default: pend_q <= pend_q;
      endcase
      if (hz.lr_done && !clr_ev) err_q <= 1'b1;
      if (stall_w && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Drive scoreboard status outputs from state.
  always_comb begin
    hz.sb_busy      = sb_busy_q;
    hz.pend_cnt     = pend_q;
    hz.sb_full      = full_w;
    hz.err_spurious = err_q;
    hz.stall_cnt    = stall_cnt_q;
  end

  // Only a net increment at full occupancy could wrap the count; the ID stall must prevent it.
  ap_no_wrap: assert property (@(posedge clk) disable iff (!rst_n) !(set_ev && !clr_ev && full_w));

endmodule

// File: tb/tb_hzu_sb.sv
// tb_hzu_sb: table-driven checks of forwarding/stall/flush plus
// hand-written scoreboard, saturation and reset sequences.
`timescale 1ns/1ps
module tb_hzu_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hzu_sb_if if0 ();
  hzu_sb_if if1 ();

  hzu_sb #(.STORE_WB_FWD(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .hz(if0.slave));
  hzu_sb #(.STORE_WB_FWD(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .hz(if1.slave));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [4:0] rs1_id, rs2_id; logic st_id;
    logic [4:0] rd_ex; logic we_ex, ld_ex; logic [4:0] rs1_ex, rs2_ex; logic br;
    logic [4:0] rd_mem; logic we_mem, ld_mem, st_mem; logic [4:0] rs2_mem;
    logic [4:0] rd_wb; logic we_wb;
    logic [1:0] fa, fb; logic fs, stall;
  } vec_t;

  typedef struct {
    logic [1:0] fa, fb; logic fs, stall, fii, fie;
  } exp_t;

  vec_t vt[21];
  exp_t q[$];
  exp_t e;
  int unsigned n_stall_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic idle0();
    if0.rs1_addr_id = '0; if0.rs2_addr_id = '0; if0.rs1_used_id = 1'b0; if0.rs2_used_id = 1'b0;
    if0.rd_addr_id = '0; if0.rd_we_id = 1'b0; if0.is_store_id = 1'b0; if0.is_long_id = 1'b0;
    if0.issue_valid_ex = 1'b0; if0.rd_addr_ex = '0; if0.rd_we_ex = 1'b0; if0.is_load_ex = 1'b0;
    if0.is_long_ex = 1'b0; if0.rs1_addr_ex = '0; if0.rs2_addr_ex = '0; if0.tk_brnch_ex = 1'b0;
    if0.rd_addr_mem = '0; if0.rd_we_mem = 1'b0; if0.is_load_mem = 1'b0; if0.is_store_mem = 1'b0;
    if0.rs2_addr_mem = '0; if0.rd_addr_wb = '0; if0.rd_we_wb = 1'b0;
    if0.lr_done = 1'b0; if0.lr_rd_addr = '0;
  endtask

  task automatic idle1();
    if1.rs1_addr_id = '0; if1.rs2_addr_id = '0; if1.rs1_used_id = 1'b0; if1.rs2_used_id = 1'b0;
    if1.rd_addr_id = '0; if1.rd_we_id = 1'b0; if1.is_store_id = 1'b0; if1.is_long_id = 1'b0;
    if1.issue_valid_ex = 1'b0; if1.rd_addr_ex = '0; if1.rd_we_ex = 1'b0; if1.is_load_ex = 1'b0;
    if1.is_long_ex = 1'b0; if1.rs1_addr_ex = '0; if1.rs2_addr_ex = '0; if1.tk_brnch_ex = 1'b0;
    if1.rd_addr_mem = '0; if1.rd_we_mem = 1'b0; if1.is_load_mem = 1'b0; if1.is_store_mem = 1'b0;
    if1.rs2_addr_mem = '0; if1.rd_addr_wb = '0; if1.rd_we_wb = 1'b0;
    if1.lr_done = 1'b0; if1.lr_rd_addr = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    idle0();
    if0.rs1_addr_id = v.rs1_id; if0.rs2_addr_id = v.rs2_id; if0.is_store_id = v.st_id;
    if0.rs1_used_id = 1'b1; if0.rs2_used_id = 1'b1;
    if0.rd_addr_ex = v.rd_ex; if0.rd_we_ex = v.we_ex; if0.is_load_ex = v.ld_ex;
    if0.rs1_addr_ex = v.rs1_ex; if0.rs2_addr_ex = v.rs2_ex; if0.tk_brnch_ex = v.br;
    if0.rd_addr_mem = v.rd_mem; if0.rd_we_mem = v.we_mem; if0.is_load_mem = v.ld_mem;
    if0.is_store_mem = v.st_mem; if0.rs2_addr_mem = v.rs2_mem;
    if0.rd_addr_wb = v.rd_wb; if0.rd_we_wb = v.we_wb;
  endtask

  task automatic long_ex0(input logic [4:0] rd);
    if0.issue_valid_ex = 1'b1; if0.is_long_ex = 1'b1; if0.rd_we_ex = 1'b1; if0.rd_addr_ex = rd;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //     rs1 rs2 st | rd we ld r1 r2 br | mrd mwe mld mst mrs2 | wrd wwe | fa fb fs stall
    vt[0]  = '{0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};
    vt[1]  = '{7, 0, 0,  7, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1};
    vt[2]  = '{0, 0, 0,  0, 0, 0, 7, 0, 0,  0, 0, 0, 0, 0,  7, 1,  2, 0, 0, 0};
    vt[3]  = '{0, 0, 0,  0, 0, 0, 7, 7, 0,  7, 1, 0, 0, 0,  7, 1,  1, 1, 0, 0};
    vt[4]  = '{0, 0, 0,  0, 0, 0, 7, 0, 0,  7, 1, 1, 0, 0,  7, 1,  2, 0, 0, 0};
    vt[5]  = '{0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 1,  0, 0, 0, 0};
    vt[6]  = '{0, 0, 0,  0, 0, 0, 7, 3, 0,  7, 0, 0, 0, 0,  3, 1,  0, 2, 0, 0};
    vt[7]  = '{0, 9, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  9, 1,  0, 0, 0, 0};
    vt[8]  = '{0, 9, 1,  9, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1};
    vt[9]  = '{0, 9, 1,  0, 0, 0, 0, 0, 0,  9, 1, 1, 0, 0,  0, 0,  0, 0, 0, 1};
    vt[10] = '{0, 9, 1,  0, 0, 0, 0, 0, 0,  9, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0};
    vt[11] = '{0, 9, 0,  9, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1};
    vt[12] = '{9, 4, 1,  9, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1};
    vt[13] = '{0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};
    vt[14] = '{0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 9,  9, 1,  0, 0, 1, 0};
    vt[15] = '{0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 9,  9, 1,  0, 0, 0, 0};
    vt[16] = '{0, 0, 0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};
    vt[17] = '{7, 0, 0,  7, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 1};
    vt[18] = '{7, 0, 0,  7, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};
    vt[19] = '{7, 0, 0,  0, 0, 0, 0, 0, 0,  7, 1, 1, 0, 0,  0, 0,  0, 0, 0, 0};
    vt[20] = '{0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 9,  9, 0,  0, 0, 0, 0};

    idle0(); idle1();
    #12;
    check("rst_sb_busy", 64'(if0.sb_busy), 64'h0);
    check("rst_pend_cnt", 64'(if0.pend_cnt), 64'h0);
    check("rst_sb_full", 64'(if0.sb_full), 64'h0);
    check("rst_err", 64'(if0.err_spurious), 64'h0);
    check("rst_stall_cnt", 64'(if0.stall_cnt), 64'h0);
    check("rst_stall", 64'(if0.stall), 64'h0);
    rst_n = 1'b1;

    // Combinational vector table through a scoreboard queue.
    n_stall_exp = 0;
    for (int i = 0; i < 21; i++) begin
      cyc();
      drive_vec(vt[i]);
      q.push_back('{vt[i].fa, vt[i].fb, vt[i].fs, vt[i].stall, vt[i].br, vt[i].br | vt[i].stall});
      if (vt[i].stall) n_stall_exp++;
      @(negedge clk);
      e = q.pop_front();
      check($sformatf("v%0d_fwd_a", i), 64'(if0.forward_a_sel), 64'(e.fa));
      check($sformatf("v%0d_fwd_b", i), 64'(if0.forward_b_sel), 64'(e.fb));
      check($sformatf("v%0d_fwd_st", i), 64'(if0.forward_store_sel), 64'(e.fs));
      check($sformatf("v%0d_stall", i), 64'(if0.stall), 64'(e.stall));
      check($sformatf("v%0d_flush_ifid", i), 64'(if0.flush_if_id), 64'(e.fii));
      check($sformatf("v%0d_flush_idex", i), 64'(if0.flush_id_ex), 64'(e.fie));
    end
    cyc(); idle0();
    @(negedge clk);
    check("table_stall_cnt", 64'(if0.stall_cnt), 64'(n_stall_exp));

    // Conservative store-data stall on WB producer.
    cyc(); idle1();
    if1.is_store_id = 1'b1; if1.rs2_addr_id = 5'd9; if1.rs2_used_id = 1'b1;
    if1.rd_addr_wb = 5'd9; if1.rd_we_wb = 1'b1;
    @(negedge clk);
    check("nofwd_store_wb_stall", 64'(if1.stall), 64'h1);
    check("nofwd_store_wb_flush", 64'(if1.flush_id_ex), 64'h1);
    cyc(); if1.rd_addr_wb = 5'd0;
    @(negedge clk);
    check("nofwd_store_wb_x0", 64'(if1.stall), 64'h0);
    cyc(); idle1();

    // Long op x5 in EX with dependent ID, completion, release.
    cyc(); idle0(); long_ex0(5'd5); if0.rs1_addr_id = 5'd5; if0.rs1_used_id = 1'b1;
    @(negedge clk);
    check("lx5_issue_stall", 64'(if0.stall), 64'h1);
    check("lx5_issue_busy", 64'(if0.sb_busy), 64'h0);
    cyc(); idle0(); if0.rs1_addr_id = 5'd5; if0.rs1_used_id = 1'b1;
    @(negedge clk);
    check("lx5_busy_stall", 64'(if0.stall), 64'h1);
    check("lx5_busy_bit", 64'(if0.sb_busy), 64'h20);
    check("lx5_pend", 64'(if0.pend_cnt), 64'h1);
    cyc(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd5;
    @(negedge clk);
    check("lx5_done_stall", 64'(if0.stall), 64'h1);
    cyc(); if0.lr_done = 1'b0;
    @(negedge clk);
    check("lx5_release_stall", 64'(if0.stall), 64'h0);
    check("lx5_release_pend", 64'(if0.pend_cnt), 64'h0);
    check("lx5_release_busy", 64'(if0.sb_busy), 64'h0);

    // Fill to MAX_PEND, full stall, WAW, concurrent set/clear, drain.
    for (int k = 1; k <= 3; k++) begin
      cyc(); idle0(); long_ex0(5'(k));
    end
    cyc(); idle0(); long_ex0(5'd4); if0.is_long_id = 1'b1;
    @(negedge clk);
    check("fill_pend3_set_stall", 64'(if0.stall), 64'h1);
    check("fill_pend3", 64'(if0.pend_cnt), 64'h3);
    cyc(); idle0(); if0.is_long_id = 1'b1; if0.rd_we_id = 1'b1; if0.rd_addr_id = 5'd6;
    @(negedge clk);
    check("full_pend", 64'(if0.pend_cnt), 64'h4);
    check("full_flag", 64'(if0.sb_full), 64'h1);
    check("full_busy", 64'(if0.sb_busy), 64'h1E);
    check("full_stall", 64'(if0.stall), 64'h1);
    cyc(); idle0(); if0.rd_we_id = 1'b1; if0.rd_addr_id = 5'd2;
    @(negedge clk);
    check("waw_stall", 64'(if0.stall), 64'h1);
    cyc(); idle0(); long_ex0(5'd6); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd1;
    cyc(); idle0();
    @(negedge clk);
    check("setclr_pend", 64'(if0.pend_cnt), 64'h4);
    check("setclr_busy", 64'(if0.sb_busy), 64'h5C);
    cyc(); idle0(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd2;
    cyc(); idle0(); if0.is_long_id = 1'b1; if0.rd_we_id = 1'b1; if0.rd_addr_id = 5'd7;
    @(negedge clk);
    check("drain_pend3", 64'(if0.pend_cnt), 64'h3);
    check("drain_not_full", 64'(if0.sb_full), 64'h0);
    check("drain_long_ok", 64'(if0.stall), 64'h0);
    cyc(); idle0(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd3;
    cyc(); idle0(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd4;
    cyc(); idle0(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd6;
    cyc(); idle0();
    @(negedge clk);
    check("drain_pend0", 64'(if0.pend_cnt), 64'h0);
    check("drain_busy0", 64'(if0.sb_busy), 64'h0);
    check("drain_err0", 64'(if0.err_spurious), 64'h0);

    // Spurious completion is sticky and leaves state alone.
    cyc(); idle0(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd3;
    cyc(); idle0();
    @(negedge clk);
    check("spur_err", 64'(if0.err_spurious), 64'h1);
    check("spur_pend", 64'(if0.pend_cnt), 64'h0);
    check("spur_busy", 64'(if0.sb_busy), 64'h0);
    cyc(); cyc();
    @(negedge clk);
    check("spur_sticky", 64'(if0.err_spurious), 64'h1);

    // Branch flush leaves scoreboard intact.
    cyc(); idle0(); long_ex0(5'd5);
    cyc(); idle0(); if0.tk_brnch_ex = 1'b1;
    @(negedge clk);
    check("br_flush_ifid", 64'(if0.flush_if_id), 64'h1);
    check("br_flush_idex", 64'(if0.flush_id_ex), 64'h1);
    cyc(); idle0();
    @(negedge clk);
    check("br_busy_kept", 64'(if0.sb_busy), 64'h20);
    cyc(); idle0(); if0.lr_done = 1'b1; if0.lr_rd_addr = 5'd5;

    // Asynchronous reset mid-operation with two pending writes.
    cyc(); idle0(); long_ex0(5'd1);
    cyc(); idle0(); long_ex0(5'd2);
    cyc(); idle0();
    @(negedge clk);
    check("pre_rst_pend", 64'(if0.pend_cnt), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pend", 64'(if0.pend_cnt), 64'h0);
    check("mid_rst_busy", 64'(if0.sb_busy), 64'h0);
    check("mid_rst_err", 64'(if0.err_spurious), 64'h0);
    check("mid_rst_stall_cnt", 64'(if0.stall_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Held stall: exact count then saturation.
    cyc(); idle0(); if0.rd_addr_ex = 5'd7; if0.rd_we_ex = 1'b1; if0.is_load_ex = 1'b1;
    if0.rs1_addr_id = 5'd7; if0.rs1_used_id = 1'b1;
    @(negedge clk);
    check("hold_stall", 64'(if0.stall), 64'h1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold_cnt10", 64'(if0.stall_cnt), 64'd10);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("hold_saturate", 64'(if0.stall_cnt), 64'hFFFF);
    cyc(); idle0();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
